// File: rtl/sda_pkg.sv
// Shared definitions for the sparse+dense polynomial accumulator:
// operation encodings, FSM state type and default word geometry.
package sda_pkg;

    // Read-modify-write operation applied to the selected dense bit
    localparam logic [1:0] SDA_XOR = 2'b00;
    localparam logic [1:0] SDA_SET = 2'b01;
    localparam logic [1:0] SDA_CLR = 2'b10;

    // Default dense word width and the matching bit-offset width
    localparam int SDA_W_DEF = 64;
    localparam int OFF_W     = $clog2(SDA_W_DEF);

    // Controller states; ST_SKIP is only reachable with range checking enabled
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S_RD = 3'd1,
        ST_D_RD = 3'd2,
        ST_D_WR = 3'd3,
        ST_SKIP = 3'd4,
        ST_FIN  = 3'd5
    } sda_state_t;

endpackage

// File: rtl/sda_mask_dec.sv
// Combinational one-hot mask decode and word update.
// Offset 0 selects the MSB of the dense word; op selects XOR / SET / CLEAR
// (the reserved encoding behaves as XOR).
module sda_mask_dec
    import sda_pkg::*;
#(
    parameter int W       = 64,
    parameter int OFF_W_P = 6
) (
    input  logic [OFF_W_P-1:0] off,
    input  logic [1:0]         op,
    input  logic [W-1:0]       word,
    output logic [W-1:0]       new_word
);

    logic [W-1:0] mask_s;

    // Build the MSB-first one-hot mask and apply the selected operation
    always_comb begin
        mask_s   = {1'b1, {(W-1){1'b0}}} >> off;
        new_word = word ^ mask_s;
        case (op)
            SDA_SET: new_word = word | mask_s;
            SDA_CLR: new_word = word & ~mask_s;
            default: new_word = word ^ mask_s;
        endcase
    end

endmodule

// File: rtl/sparse_dense_acc.sv
// Sparse+dense GF(2)[x]/(x^R-1) accumulator.
// For each sparse entry k: read the bit index from sparse RAM (s_base+k), read the
// dense word holding that bit, write it back with the bit XORed / set / cleared.
// Optional feature macro: SDA_RANGE_CHK_EN -- indices >= R raise the sticky err
// flag and are skipped; when undefined every index is written and err stays 0.
module sparse_dense_acc
    import sda_pkg::*;
#(
    parameter int R        = 10163,
    parameter int W        = 64,
    parameter int IDX_W    = 14,
    parameter int S_ADDR_W = 7,
    parameter int D_ADDR_W = 8,
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [S_ADDR_W:0]   n_ent,
    input  logic [S_ADDR_W-1:0] s_base,
    input  logic [D_ADDR_W-1:0] d_base,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [S_ADDR_W-1:0] s_addr,
    input  logic [IDX_W-1:0]    s_rdata,
    output logic [D_ADDR_W-1:0] d_addr,
    output logic                d_we,
    output logic [W-1:0]        d_wdata,
    input  logic [W-1:0]        d_rdata
);

    localparam int OFF_W_L = $clog2(W);
    localparam int CNT_W   = $clog2(RD_LAT + 2);
`ifdef SDA_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif
    localparam logic [IDX_W:0]    R_L     = (IDX_W + 1)'(R);
    localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(RD_LAT);
    localparam logic [S_ADDR_W:0] K_ONE   = (S_ADDR_W + 1)'(1);

    sda_state_t          state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [S_ADDR_W:0]   k_r, k_s, n_r, n_s;
    logic [1:0]          op_r, op_s;
    logic [S_ADDR_W-1:0] s_base_r, s_base_s, s_addr_r, s_addr_s;
    logic [D_ADDR_W-1:0] d_base_r, d_base_s, d_addr_r, d_addr_s;
    logic [OFF_W_L-1:0]  off_r, off_s;
    logic                busy_r, busy_s, done_r, done_s, err_r, err_s, d_we_r, d_we_s;
    logic [W-1:0]        d_wdata_r, d_wdata_s, dec_word_s;
    logic                oor_s;

    sda_mask_dec #(.W(W), .OFF_W_P(OFF_W_L)) u_dec (
        .off      (off_r),
        .op       (op_r),
        .word     (d_rdata),
        .new_word (dec_word_s)
    );

    // Next-state and next-output logic; all outputs are registered from these values
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        k_s       = k_r;
        n_s       = n_r;
        op_s      = op_r;
        s_base_s  = s_base_r;
        d_base_s  = d_base_r;
        s_addr_s  = s_addr_r;
        d_addr_s  = d_addr_r;
        off_s     = off_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = err_r;
        d_we_s    = 1'b0;
        d_wdata_s = d_wdata_r;
        oor_s     = RANGE_CHK && ({1'b0, s_rdata} >= R_L);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s     = op;
                    n_s      = n_ent;
                    s_base_s = s_base;
                    d_base_s = d_base;
                    k_s      = '0;
                    cnt_s    = '0;
                    err_s    = 1'b0;
                    busy_s   = 1'b1;
                    if (n_ent != '0) begin
                        state_s  = ST_S_RD;
                        s_addr_s = s_base;
                    end else begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_S_RD: begin
                if (cnt_r == LAST_RD) begin
                    cnt_s = '0;
                    off_s = s_rdata[OFF_W_L-1:0];
                    if (oor_s) begin
                        err_s   = 1'b1;
                        state_s = ST_SKIP;
                    end else begin
                        state_s  = ST_D_RD;
                        d_addr_s = d_base_r + D_ADDR_W'(s_rdata >> OFF_W_L);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_D_RD: begin
                if (cnt_r == LAST_RD) begin
                    cnt_s     = '0;
                    state_s   = ST_D_WR;
                    d_we_s    = 1'b1;
                    d_wdata_s = dec_word_s;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_D_WR, ST_SKIP: begin
                if ((k_r + K_ONE) == n_r) begin
                    state_s = ST_FIN;
                    done_s  = 1'b1;
                end else begin
                    k_s      = k_r + K_ONE;
                    state_s  = ST_S_RD;
                    s_addr_s = s_base_r + S_ADDR_W'(k_r + K_ONE);
                end
            end
            ST_FIN: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched job parameters and registered outputs; reset aborts any job
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            k_r       <= '0;
            n_r       <= '0;
            op_r      <= SDA_XOR;
            s_base_r  <= '0;
            d_base_r  <= '0;
            s_addr_r  <= '0;
            d_addr_r  <= '0;
            off_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            d_we_r    <= 1'b0;
            d_wdata_r <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            k_r       <= k_s;
            n_r       <= n_s;
            op_r      <= op_s;
            s_base_r  <= s_base_s;
            d_base_r  <= d_base_s;
            s_addr_r  <= s_addr_s;
            d_addr_r  <= d_addr_s;
            off_r     <= off_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            d_we_r    <= d_we_s;
            d_wdata_r <= d_wdata_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign s_addr  = s_addr_r;
    assign d_addr  = d_addr_r;
    assign d_we    = d_we_r;
    assign d_wdata = d_wdata_r;

endmodule

// File: tb/tb_sparse_dense_acc.sv
// Self-checking bench for sparse_dense_acc: RAM models with read latency,
// a word/bit-level reference model of the accumulation, and scenario tasks.
module tb_sparse_dense_acc;

    localparam int R        = 10163;
    localparam int W        = 64;
    localparam int IDX_W    = 14;
    localparam int S_ADDR_W = 7;
    localparam int D_ADDR_W = 8;
    localparam int RD_LAT   = 2;
    localparam int S_DEPTH  = 1 << S_ADDR_W;
    localparam int D_DEPTH  = 1 << D_ADDR_W;
    localparam int ENT_CYC  = 2 * RD_LAT + 3;
    localparam int SKIP_CYC = RD_LAT + 2;
`ifdef SDA_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, start, busy, done, err, d_we;
    logic [1:0]          op;
    logic [S_ADDR_W:0]   n_ent;
    logic [S_ADDR_W-1:0] s_base, s_addr;
    logic [D_ADDR_W-1:0] d_base, d_addr;
    logic [IDX_W-1:0]    s_rdata;
    logic [W-1:0]        d_wdata, d_rdata;

    always #5 clk = ~clk;

    sparse_dense_acc #(.R(R), .W(W), .IDX_W(IDX_W), .S_ADDR_W(S_ADDR_W),
                       .D_ADDR_W(D_ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .n_ent(n_ent),
        .s_base(s_base), .d_base(d_base), .busy(busy), .done(done), .err(err),
        .s_addr(s_addr), .s_rdata(s_rdata), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    // RAM models: RD_LAT-cycle read pipelines, dense write on d_we
    logic [IDX_W-1:0] smem [S_DEPTH];
    logic [W-1:0]     dmem [D_DEPTH];
    logic [IDX_W-1:0] s_pipe [RD_LAT];
    logic [W-1:0]     d_pipe [RD_LAT];
    int               wr_cnt = 0;
    logic [D_ADDR_W-1:0] last_addr;
    logic [W-1:0]        last_data;

    always @(posedge clk) begin
        s_pipe[0] <= smem[s_addr];
        d_pipe[0] <= dmem[d_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            s_pipe[i] <= s_pipe[i-1];
            d_pipe[i] <= d_pipe[i-1];
        end
        if (d_we === 1'b1) begin
            dmem[d_addr] <= d_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_addr    <= d_addr;
            last_data    <= d_wdata;
        end
    end
    assign s_rdata = s_pipe[RD_LAT-1];
    assign d_rdata = d_pipe[RD_LAT-1];

    int tests = 0;
    int fails = 0;

    // Reference model results
    logic [W-1:0] exp_mem [D_DEPTH];
    int exp_wr, exp_cyc;
    bit exp_err;

    // Measured job results
    int  m_cyc, m_wr;
    bit  m_to;

    task automatic model(input logic [1:0] o, input int n, input int sb, input int db);
        int idx, a;
        logic [W-1:0] m;
        for (int i = 0; i < D_DEPTH; i++) exp_mem[i] = dmem[i];
        exp_wr = 0; exp_cyc = 1; exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = int'(smem[(sb + k) % S_DEPTH]);
            if (CHK && idx >= R) begin
                exp_err = 1'b1;
                exp_cyc += SKIP_CYC;
            end else begin
                a = (db + idx / W) % D_DEPTH;
                m = 64'd1 << (W - 1 - (idx % W));
                case (o)
                    2'b01:   exp_mem[a] = exp_mem[a] | m;
                    2'b10:   exp_mem[a] = exp_mem[a] & ~m;
                    default: exp_mem[a] = exp_mem[a] ^ m;
                endcase
                exp_wr++;
                exp_cyc += ENT_CYC;
            end
        end
    endtask

    // Issue one job; scramble inputs after start; optionally pulse start at cycle poke
    task automatic run_job(input logic [1:0] o, input int n, input int sb, input int db,
                           input int poke);
        int w0;
        @(negedge clk);
        op = o; n_ent = (S_ADDR_W+1)'(n); s_base = S_ADDR_W'(sb); d_base = D_ADDR_W'(db);
        start = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); n_ent = (S_ADDR_W+1)'($urandom);
        s_base = S_ADDR_W'($urandom); d_base = D_ADDR_W'($urandom);
        m_cyc = 1; m_to = 1'b0;
        while (done !== 1'b1) begin
            if (m_cyc >= 3000) begin
                m_to = 1'b1;
                break;
            end
            @(negedge clk);
            m_cyc++;
            start = (m_cyc == poke) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        m_wr = wr_cnt - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; n_ent = '0; s_base = '0; d_base = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, err, d_we} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, d_we});
        end
        tests++;
        if (s_addr !== 7'd0 || d_addr !== 8'd0) begin
            fails++; $display("FAIL reset_addr got s=%0h d=%0h want 0 0", s_addr, d_addr);
        end
        tests++;
        if (d_wdata !== 64'd0) begin
            fails++; $display("FAIL reset_wdata got %h want 0", d_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_xor();
        smem[20] = 14'd130;
        dmem[12] = 64'd0;
        run_job(2'b00, 1, 20, 10, 0);
        tests++;
        if (m_to || m_cyc + 1 !== 9) begin
            fails++; $display("FAIL single_latency got %0d want 9 (timeout=%0d)", m_cyc + 1, m_to);
        end
        tests++;
        if (m_wr !== 1 || last_addr !== 8'd12) begin
            fails++; $display("FAIL single_write got n=%0d addr=%0d want 1 12", m_wr, last_addr);
        end
        tests++;
        if (last_data !== 64'h2000_0000_0000_0000) begin
            fails++; $display("FAIL single_data got %h want 2000000000000000", last_data);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL single_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_repeat_idx();
        smem[0] = 14'd5; smem[1] = 14'd5; dmem[0] = 64'd0;
        run_job(2'b00, 2, 0, 0, 0);
        tests++;
        if (m_wr !== 2 || dmem[0] !== 64'd0) begin
            fails++; $display("FAIL repeat_xor got n=%0d word=%h want 2 0", m_wr, dmem[0]);
        end
    endtask

    task automatic test_set_clear();
        smem[40] = 14'd63; dmem[0] = 64'd1;
        run_job(2'b01, 1, 40, 0, 0);
        tests++;
        if (last_data !== 64'd1) begin
            fails++; $display("FAIL set_63 got %h want 1", last_data);
        end
        run_job(2'b10, 1, 40, 0, 0);
        tests++;
        if (last_data !== 64'd0 || dmem[0] !== 64'd0) begin
            fails++; $display("FAIL clear_63 got %h mem=%h want 0", last_data, dmem[0]);
        end
    endtask

    task automatic test_zero_entries();
        logic [S_ADDR_W-1:0] sa0;
        sa0 = s_addr;
        run_job(2'b00, 0, 77, 3, 0);
        tests++;
        if (m_to || m_cyc !== 1 || m_wr !== 0) begin
            fails++; $display("FAIL zero_ent got cyc=%0d wr=%0d want 1 0", m_cyc, m_wr);
        end
        tests++;
        if (s_addr !== sa0) begin
            fails++; $display("FAIL zero_saddr got %0d want %0d", s_addr, sa0);
        end
    endtask

    task automatic check_against_model(input string tag);
        int bad = 0;
        for (int i = 0; i < D_DEPTH; i++) if (dmem[i] !== exp_mem[i]) bad++;
        tests++;
        if (m_to || m_cyc !== exp_cyc || m_wr !== exp_wr) begin
            fails++;
            $display("FAIL %s_timing got cyc=%0d wr=%0d want cyc=%0d wr=%0d", tag, m_cyc, m_wr, exp_cyc, exp_wr);
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL %s_mem got %0d wrong words want 0", tag, bad);
        end
        tests++;
        if (err !== exp_err) begin
            fails++; $display("FAIL %s_err got %b want %b", tag, err, exp_err);
        end
    endtask

    task automatic fill_random(input int pct_bad);
        for (int i = 0; i < S_DEPTH; i++)
            smem[i] = (CHK && $urandom_range(99, 0) < pct_bad) ?
                      IDX_W'($urandom_range(16383, R)) : IDX_W'($urandom_range(R - 1, 0));
        for (int i = 0; i < D_DEPTH; i++) dmem[i] = {$urandom, $urandom};
    endtask

    task automatic test_random_ops();
        logic [1:0] o;
        int n, sb, db;
        for (int t = 0; t < 8; t++) begin
            fill_random(15);
            o = 2'($urandom_range(3, 0)); n = $urandom_range(12, 1);
            sb = $urandom_range(S_DEPTH - 1, 0); db = $urandom_range(D_DEPTH - 1, 0);
            if (t == 0) begin sb = S_DEPTH - 3; smem[sb] = IDX_W'(R - 1); end
            if (t == 1) smem[sb + 1] = smem[sb];
            model(o, n, sb, db);
            run_job(o, n, sb, db, 0);
            check_against_model("random");
        end
    endtask

    task automatic test_range();
        smem[0] = 14'd10163; smem[1] = 14'd7; dmem[0] = 64'd0;
        model(2'b00, 2, 0, 0);
        run_job(2'b00, 2, 0, 0, 0);
        check_against_model("range");
`ifdef SDA_RANGE_CHK_EN
        tests++;
        if (err !== 1'b1 || m_wr !== 1 || last_addr !== 8'd0 || last_data !== 64'h0100_0000_0000_0000) begin
            fails++;
            $display("FAIL range_vec got err=%b wr=%0d addr=%0d data=%h want 1 1 0 0100000000000000",
                     err, m_wr, last_addr, last_data);
        end
        smem[5] = 14'd100;
        run_job(2'b00, 1, 5, 0, 0);
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL range_clear got err=%b want 0", err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int w0, w1;
        fill_random(0);
        w0 = wr_cnt;
        @(negedge clk);
        op = 2'b00; n_ent = 8'd67; s_base = 7'd9; d_base = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);   // now in cycle 19: D_RD of entry 3
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (d_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL rst_mid got we=%b busy=%b done=%b want 0 0 0", d_we, busy, done);
        end
        rst = 1'b0;
        w1 = wr_cnt;
        repeat (12) @(negedge clk);
        tests++;
        if (wr_cnt !== w1 || w1 - w0 !== 2) begin
            fails++; $display("FAIL rst_writes got before=%0d after=%0d want 2 0", w1 - w0, wr_cnt - w1);
        end
        model(2'b01, 3, 30, 40);
        run_job(2'b01, 3, 30, 40, 0);
        check_against_model("restart");
    endtask

    task automatic test_back_to_back();
        fill_random(10);
        model(2'b10, 4, 100, 200);
        run_job(2'b10, 4, 100, 200, 5);
        check_against_model("b2b_first");
        model(2'b00, 5, 126, 250);
        run_job(2'b00, 5, 126, 250, 0);
        check_against_model("b2b_second");
    endtask

    initial begin
        for (int i = 0; i < S_DEPTH; i++) smem[i] = '0;
        for (int i = 0; i < D_DEPTH; i++) dmem[i] = '0;
        test_reset();
        test_single_xor();
        test_repeat_idx();
        test_set_clear();
        test_zero_entries();
        test_random_ops();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
